m_param_fifo: RTL and testbench
===============================

// Module: m_param_fifo
// PURPOSE
//   Parametrised single-clock circular FIFO; successor to the 1-bit fixed-page queue.
//   Generic data width and depth; usable capacity is the full DEPTH entries.
//   Accepts enqueue and dequeue in the same cycle, reports occupancy and threshold flags,
//   and raises sticky overflow/underflow errors. Sits between MPU producer/consumer stages.
// PARAMETERS
//   WIDTH     8     data word width in bits (>=1)
//   DEPTH     1024  number of entries (>=2, need not be a power of two)
//   AF_LEVEL  DEPTH-2  almost_full asserted when count >= AF_LEVEL
//   AE_LEVEL  2     almost_empty asserted when count <= AE_LEVEL
//   FWFT      0     0: registered read (1-cycle latency); 1: first-word-fall-through
// PORTS
//   clk           in   1                 rising-edge clock
//   reset         in   1                 asynchronous, active-low reset
//   enqueue       in   1                 write request
//   data_i        in   WIDTH             write data
//   dequeue       in   1                 read request
//   data_o        out  WIDTH             read data
//   data_valid    out  1                 data_o holds valid data
//   flush         in   1                 synchronous empty
//   clear_err     in   1                 synchronous clear of overflow/underflow
//   count         out  $clog2(DEPTH+1)   current occupancy, 0..DEPTH
//   is_full       out  1                 count == DEPTH
//   is_empty      out  1                 count == 0
//   almost_full   out  1                 see AF_LEVEL
//   almost_empty  out  1                 see AE_LEVEL
//   overflow      out  1                 sticky: enqueue requested while full
//   underflow     out  1                 sticky: dequeue requested while empty
// BEHAVIOUR
//   Reset (reset=0, async): head=tail=count=0, is_empty=1, almost_empty=1, is_full=0,
//     almost_full=0, overflow=underflow=0, data_o=0, data_valid=0. Memory contents not reset.
//   Accept rules use registered state: wr_ok = enqueue & ~is_full; rd_ok = dequeue & ~is_empty.
//   Simultaneous: both accepted -> count unchanged, tail and head both advance.
//     When full, only dequeue is accepted; enqueue is dropped and sets overflow.
//     When empty, only enqueue is accepted; dequeue sets underflow. No write-to-read bypass.
//   Pointers: wrap from DEPTH-1 to 0 by explicit compare (no modulo); width $clog2(DEPTH).
//   count_next = count + wr_ok - rd_ok. All flags are registered and derived from count_next,
//     so they are valid in the cycle after the causing edge.
//   FWFT=0: on rd_ok, data_o <= mem[head] and data_valid=1 the next cycle (1-cycle pulse);
//     without rd_ok, data_valid=0 and data_o holds its last value.
//   FWFT=1: data_o = mem[head] (combinational read), data_valid = ~is_empty; dequeue pops it.
//   flush: highest priority over enqueue/dequeue. Sets head=tail=count=0 and all flags to their
//     reset values, except overflow and underflow, which keep their values. data_valid=0.
//   clear_err: clears overflow/underflow. If a new error occurs in the same cycle, set wins.
//   Reset mid-operation: all state returns to reset values immediately; queued data is lost.
// STRUCTURE
//   Shared package/include m_fifo_pkg: clog2 function and default WIDTH/DEPTH constants.
//   Sub-module m_fifo_ram: simple dual-port RAM (1 sync write, 1 read; registered or comb
//     read selected by FWFT) for BRAM inference. Pointer/count/flag control stays in top.
// TESTING (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
//   1 Reset, then 4 enqueues 0x11..0x44 -> count 1,2,3,4; almost_full at count 3;
//     is_full=1 after 4th; 5th enqueue 0x55 -> dropped, overflow=1.
//   2 FWFT=0: 4 dequeues from full -> data_o 0x11,0x22,0x33,0x44, each with a 1-cycle
//     data_valid pulse one cycle after the request; then is_empty=1; 5th dequeue -> underflow=1.
//   3 Wrap: repeat 3 enq / 3 deq for 10 rounds -> strict FIFO order, count returns to 0,
//     pointers wrap 3->0 with no loss.
//   4 Simultaneous enq+deq at count=2 -> count stays 2; at full -> deq ok, enq dropped,
//     overflow=1; at empty -> enq ok, count=1, underflow=1.
//   5 flush at count=3 with overflow=1 -> next cycle count=0, is_empty=1, overflow still 1;
//     clear_err -> overflow=0. Reset asserted mid-burst -> all outputs at reset values at once.
//   6 FWFT=1: enqueue 0xA5 into empty -> next cycle data_o=0xA5, data_valid=1;
//     dequeue -> data_valid=0.

Source files
------------

// File: rtl/m_fifo_pkg.sv
// Package: m_fifo_pkg
// Purpose: Shared definitions for the parametrised FIFO slice.
//   - DEF_WIDTH / DEF_DEPTH : default data width and depth
//   - clog2()               : elaboration-time ceiling log2 for pointer/count widths
//   - fifo_flags_t          : bundle of the registered occupancy flags
//   - FLAGS_RST             : flag values after reset or flush (empty FIFO)
package m_fifo_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 1024;

   // Ceiling log2; clog2(1) = 0, clog2(4) = 2, clog2(5) = 3.
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic afull;
      logic aempty;
   } fifo_flags_t;

   localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

endpackage

// File: rtl/m_fifo_ram.sv
// Module: m_fifo_ram
// Purpose: Simple dual-port storage for the FIFO (one synchronous write port,
//   one read port). FWFT=0 gives a registered read, FWFT=1 a combinational read.
// Ports:
//   i_clk    clock               i_rst_n  async active-low reset (read register only)
//   i_we     write enable        i_waddr  write address     i_wdata  write data
//   i_re     read enable         i_raddr  read address      o_rdata  read data
module m_fifo_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int FWFT  = 0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   // Storage is intentionally not reset so it can map onto block RAM.
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read register holds its value between reads, so data_o is stable after a pop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = (FWFT != 0) ? r_mem[i_raddr] : r_rdata;

endmodule

// File: rtl/m_param_fifo.sv
// Module: m_param_fifo
// Purpose: Single-clock circular FIFO with full DEPTH capacity, simultaneous
//   enqueue/dequeue, registered occupancy flags and sticky error flags.
// Ports:
//   i_clk, i_rst_n              clock, async active-low reset
//   i_enqueue, i_data           write request and data
//   i_dequeue                   read request
//   o_data, o_data_valid        read data and its valid indication
//   i_flush, i_clear_err        synchronous empty, synchronous error clear
//   o_count                     occupancy 0..DEPTH
//   o_is_full, o_is_empty       count == DEPTH, count == 0
//   o_almost_full/empty         count >= AF_LEVEL, count <= AE_LEVEL
//   o_overflow, o_underflow     sticky: enqueue while full, dequeue while empty
module m_param_fifo
   import m_fifo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_enqueue,
   input  logic [WIDTH-1:0]            i_data,
   input  logic                        i_dequeue,
   output logic [WIDTH-1:0]            o_data,
   output logic                        o_data_valid,
   input  logic                        i_flush,
   input  logic                        i_clear_err,
   output logic [clog2(DEPTH+1)-1:0]   o_count,
   output logic                        o_is_full,
   output logic                        o_is_empty,
   output logic                        o_almost_full,
   output logic                        o_almost_empty,
   output logic                        o_overflow,
   output logic                        o_underflow
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);

   logic [AW-1:0]    r_head;
   logic [AW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   fifo_flags_t      r_flags;
   logic             r_overflow;
   logic             r_underflow;
   logic             r_data_valid;

   logic             w_wr_ok;
   logic             w_rd_ok;
   logic [AW-1:0]    w_head_next;
   logic [AW-1:0]    w_tail_next;
   logic [CW-1:0]    w_count_next;
   fifo_flags_t      w_flags_next;
   logic             w_overflow_next;
   logic             w_underflow_next;
   logic [WIDTH-1:0] w_rdata;

   // Wrap by compare so DEPTH need not be a power of two.
   function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      // Acceptance uses the registered flags; flush blocks both sides.
      w_wr_ok = i_enqueue & ~r_flags.full  & ~i_flush;
      w_rd_ok = i_dequeue & ~r_flags.empty & ~i_flush;

      w_head_next  = r_head;
      w_tail_next  = r_tail;
      w_count_next = r_count;
      w_flags_next = FLAGS_RST;
      if (i_flush) begin
         w_head_next  = '0;
         w_tail_next  = '0;
         w_count_next = '0;
      end else begin
         if (w_wr_ok) w_tail_next = f_inc(r_tail);
         if (w_rd_ok) w_head_next = f_inc(r_head);
         w_count_next = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
         w_flags_next.full   = (w_count_next == CW'(DEPTH));
         w_flags_next.empty  = (w_count_next == '0);
         w_flags_next.afull  = (w_count_next >= CW'(AF_LEVEL));
         w_flags_next.aempty = (w_count_next <= CW'(AE_LEVEL));
      end

      // A new error in the same cycle as clear_err wins; flush leaves errors alone.
      w_overflow_next  = (r_overflow  & ~i_clear_err) | (i_enqueue & r_flags.full  & ~i_flush);
      w_underflow_next = (r_underflow & ~i_clear_err) | (i_dequeue & r_flags.empty & ~i_flush);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
         r_flags      <= FLAGS_RST;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
         r_data_valid <= 1'b0;
      end else begin
         r_head       <= w_head_next;
         r_tail       <= w_tail_next;
         r_count      <= w_count_next;
         r_flags      <= w_flags_next;
         r_overflow   <= w_overflow_next;
         r_underflow  <= w_underflow_next;
         r_data_valid <= w_rd_ok;
      end
   end

   m_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW),
      .FWFT  (FWFT)
   ) u_ram (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_wr_ok),
      .i_waddr (r_tail),
      .i_wdata (i_data),
      .i_re    (w_rd_ok),
      .i_raddr (r_head),
      .o_rdata (w_rdata)
   );

   // In FWFT mode the head word is shown only while the FIFO holds data, so an
   // empty FIFO (including after reset) presents zero instead of stale memory.
   assign o_data         = ((FWFT != 0) && r_flags.empty) ? '0 : w_rdata;
   assign o_data_valid   = (FWFT != 0) ? ~r_flags.empty : r_data_valid;
   assign o_count        = r_count;
   assign o_is_full      = r_flags.full;
   assign o_is_empty     = r_flags.empty;
   assign o_almost_full  = r_flags.afull;
   assign o_almost_empty = r_flags.aempty;
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_m_param_fifo.sv
module tb_m_param_fifo;

   logic       clk;
   logic       rst_n;
   // registered-read instance
   logic       enq, deq, flush, clr;
   logic [7:0] din, dout;
   logic       dv, full, empty, af, ae, ovf, udf;
   logic [2:0] cnt;
   // FWFT instance
   logic       enq1, deq1, flush1, clr1;
   logic [7:0] din1, dout1;
   logic       dv1, full1, empty1, af1, ae1, ovf1, udf1;
   logic [2:0] cnt1;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];

   m_param_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_enqueue(enq), .i_data(din), .i_dequeue(deq),
      .o_data(dout), .o_data_valid(dv), .i_flush(flush), .i_clear_err(clr),
      .o_count(cnt), .o_is_full(full), .o_is_empty(empty), .o_almost_full(af),
      .o_almost_empty(ae), .o_overflow(ovf), .o_underflow(udf)
   );

   m_param_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_enqueue(enq1), .i_data(din1), .i_dequeue(deq1),
      .o_data(dout1), .o_data_valid(dv1), .i_flush(flush1), .i_clear_err(clr1),
      .o_count(cnt1), .o_is_full(full1), .o_is_empty(empty1), .o_almost_full(af1),
      .o_almost_empty(ae1), .o_overflow(ovf1), .o_underflow(udf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_pop(input string tag);
      logic [7:0] e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s scoreboard empty observed=%0h", tag, dout);
      end else begin
         e = sb.pop_front();
         chk(tag, {24'd0, dout}, {24'd0, e});
      end
   endtask

   task automatic push(input logic [7:0] d);
      enq = 1'b1; din = d; sb.push_back(d);
      cyc();
      enq = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_count"}, {29'd0, cnt}, 0);
      chk({tag, "_empty"}, {31'd0, empty}, 1);
      chk({tag, "_aempty"}, {31'd0, ae}, 1);
      chk({tag, "_full"}, {31'd0, full}, 0);
      chk({tag, "_afull"}, {31'd0, af}, 0);
      chk({tag, "_ovf"}, {31'd0, ovf}, 0);
      chk({tag, "_udf"}, {31'd0, udf}, 0);
      chk({tag, "_dout"}, {24'd0, dout}, 0);
      chk({tag, "_dv"}, {31'd0, dv}, 0);
      chk({tag, "_dv1"}, {31'd0, dv1}, 0);
      chk({tag, "_empty1"}, {31'd0, empty1}, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      enq = 0; deq = 0; flush = 0; clr = 0; din = 0;
      enq1 = 0; deq1 = 0; flush1 = 0; clr1 = 0; din1 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst_n = 1'b1;

      // 1: fill to full, then overflow
      for (int i = 0; i < 4; i++) begin
         push(8'((i + 1) * 17));
         chk("t1_count", {29'd0, cnt}, i + 1);
         chk("t1_afull", {31'd0, af}, (i >= 2) ? 1 : 0);
         chk("t1_full", {31'd0, full}, (i == 3) ? 1 : 0);
         $display("t1 enqueue %0d count=%0d", i, cnt);
      end
      enq = 1'b1; din = 8'h55;
      cyc();
      enq = 1'b0;
      chk("t1_ovf", {31'd0, ovf}, 1);
      chk("t1_count_after_drop", {29'd0, cnt}, 4);

      // 2: drain with registered read, then underflow
      for (int i = 0; i < 4; i++) begin
         deq = 1'b1;
         cyc();
         deq = 1'b0;
         chk("t2_dv", {31'd0, dv}, 1);
         chk_pop("t2_data");
         chk("t2_count", {29'd0, cnt}, 3 - i);
         $display("t2 dequeue %0d data=%0h", i, dout);
         cyc();
         chk("t2_dv_pulse", {31'd0, dv}, 0);
      end
      chk("t2_empty", {31'd0, empty}, 1);
      deq = 1'b1;
      cyc();
      deq = 1'b0;
      chk("t2_udf", {31'd0, udf}, 1);
      chk("t2_dv_udf", {31'd0, dv}, 0);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("t2_clr_ovf", {31'd0, ovf}, 0);
      chk("t2_clr_udf", {31'd0, udf}, 0);

      // 3: wrap-around rounds
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 3; k++) push(8'(r * 16 + k + 1));
         chk("t3_count3", {29'd0, cnt}, 3);
         deq = 1'b1;
         for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t3_dv", {31'd0, dv}, 1);
            chk_pop("t3_data");
         end
         deq = 1'b0;
         chk("t3_count0", {29'd0, cnt}, 0);
         $display("t3 round %0d last=%0h", r, dout);
      end
      chk("t3_udf", {31'd0, udf}, 0);

      // 4: simultaneous enqueue/dequeue
      push(8'h61);
      push(8'h62);
      enq = 1'b1; deq = 1'b1; din = 8'h63; sb.push_back(8'h63);
      cyc();
      enq = 1'b0; deq = 1'b0;
      chk("t4_mid_count", {29'd0, cnt}, 2);
      chk("t4_mid_dv", {31'd0, dv}, 1);
      chk_pop("t4_mid_data");
      push(8'h64);
      push(8'h65);
      chk("t4_full", {31'd0, full}, 1);
      enq = 1'b1; deq = 1'b1; din = 8'h66;
      cyc();
      enq = 1'b0; deq = 1'b0;
      chk("t4_full_count", {29'd0, cnt}, 3);
      chk("t4_full_ovf", {31'd0, ovf}, 1);
      chk_pop("t4_full_data");
      deq = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk_pop("t4_drain");
      end
      deq = 1'b0;
      enq = 1'b1; deq = 1'b1; din = 8'h67; sb.push_back(8'h67);
      cyc();
      enq = 1'b0; deq = 1'b0;
      chk("t4_empty_count", {29'd0, cnt}, 1);
      chk("t4_empty_udf", {31'd0, udf}, 1);
      chk("t4_empty_dv", {31'd0, dv}, 0);
      $display("t4 simultaneous done count=%0d", cnt);

      // 5: flush keeps errors, clear_err clears them, reset mid-burst
      push(8'h71);
      push(8'h72);
      chk("t5_count3", {29'd0, cnt}, 3);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      sb.delete();
      chk("t5_fl_count", {29'd0, cnt}, 0);
      chk("t5_fl_empty", {31'd0, empty}, 1);
      chk("t5_fl_aempty", {31'd0, ae}, 1);
      chk("t5_fl_afull", {31'd0, af}, 0);
      chk("t5_fl_ovf", {31'd0, ovf}, 1);
      chk("t5_fl_udf", {31'd0, udf}, 1);
      chk("t5_fl_dv", {31'd0, dv}, 0);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("t5_clr_ovf", {31'd0, ovf}, 0);
      push(8'h81);
      deq = 1'b1;
      cyc();
      deq = 1'b0;
      chk_pop("t5_after_flush");
      deq = 1'b1;
      cyc();
      deq = 1'b0;
      chk("t5_udf_pre_rst", {31'd0, udf}, 1);
      enq = 1'b1; din = 8'h91;
      cyc();
      din = 8'h92;
      cyc();
      #2;
      rst_n = 1'b0;
      #1;
      enq = 1'b0;
      sb.delete();
      chk_reset_state("t5_midrst");
      $display("t5 mid-burst reset count=%0d", cnt);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // 6: first-word-fall-through instance
      enq1 = 1'b1; din1 = 8'hA5;
      cyc();
      enq1 = 1'b0;
      chk("t6_data", {24'd0, dout1}, 32'hA5);
      chk("t6_dv", {31'd0, dv1}, 1);
      chk("t6_count", {29'd0, cnt1}, 1);
      deq1 = 1'b1;
      cyc();
      deq1 = 1'b0;
      chk("t6_dv_after_deq", {31'd0, dv1}, 0);
      chk("t6_empty", {31'd0, empty1}, 1);
      enq1 = 1'b1; din1 = 8'h5A;
      cyc();
      din1 = 8'h3C;
      cyc();
      enq1 = 1'b0;
      chk("t6_head0", {24'd0, dout1}, 32'h5A);
      deq1 = 1'b1;
      cyc();
      chk("t6_head1", {24'd0, dout1}, 32'h3C);
      chk("t6_dv_head1", {31'd0, dv1}, 1);
      cyc();
      deq1 = 1'b0;
      chk("t6_dv_end", {31'd0, dv1}, 0);
      $display("t6 fwft done count=%0d", cnt1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
